// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and defaults for the start-light responder logic
package f1_pkg;

    localparam int MAX_MS_DEF = 9999;

    typedef logic [13:0] ms_t;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TIMING,
        DONE,
        JUMP
    } react_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, tick-based debouncer and press-edge detector
module btn_debounce #(
    parameter int DEBOUNCE_MS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample;

    // level is active-high "pressed"; the raw button is active-low
    assign sample = ~sync2_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (tick) begin
            if (sample == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
                cnt_d   = '0;
                level_d = sample;
                press_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - measures driver reaction after lights-out, flags jump starts, keeps best time
module reaction_timer
    import f1_pkg::*;
#(
    parameter int DEBOUNCE_MS = 5,
    parameter int MAX_MS      = MAX_MS_DEF,
    parameter int CNT_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_ms,
    input  logic             arm,
    input  logic             lights_out,
    input  logic             btn_n,
    input  logic             clear_best,
    output logic [CNT_W-1:0] react_ms,
    output logic             react_valid,
    output logic             timeout,
    output logic             jump_start,
    output logic [CNT_W-1:0] best_ms,
    output logic             best_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_MS);

    react_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] react_q, react_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic             react_valid_q, react_valid_d;
    logic             timeout_q, timeout_d;
    logic             jump_q, jump_d;
    logic             best_valid_q, best_valid_d;
    logic             btn_level;
    logic             press;

    btn_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick_ms),
        .btn_n (btn_n),
        .level (btn_level),
        .press (press)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        react_d       = react_q;
        react_valid_d = 1'b0;
        timeout_d     = timeout_q;
        jump_d        = jump_q;
        best_d        = best_q;
        best_valid_d  = best_valid_q;

        case (state_q)
            IDLE, DONE, JUMP: begin
                if (arm) begin
                    state_d   = ARMED;
                    jump_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ARMED: begin
                // press together with lights_out is a legal zero-time reaction
                if (press && lights_out) begin
                    state_d       = DONE;
                    react_d       = '0;
                    react_valid_d = 1'b1;
                end else if (press) begin
                    state_d = JUMP;
                    jump_d  = 1'b1;
                end else if (lights_out) begin
                    state_d = TIMING;
                    cnt_d   = '0;
                end
            end
            TIMING: begin
                if (press) begin
                    state_d       = DONE;
                    react_d       = cnt_q;
                    react_valid_d = 1'b1;
                end else if (tick_ms) begin
                    if (cnt_q == MAX_V - 1'b1) begin
                        state_d       = DONE;
                        cnt_d         = MAX_V;
                        react_d       = MAX_V;
                        timeout_d     = 1'b1;
                        react_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_best) begin
            best_d       = '0;
            best_valid_d = 1'b0;
        end else if (react_valid_d && !timeout_d &&
                     (!best_valid_q || react_d < best_q)) begin
            best_d       = react_d;
            best_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            react_q       <= '0;
            react_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            jump_q        <= 1'b0;
            best_q        <= '0;
            best_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            react_q       <= react_d;
            react_valid_q <= react_valid_d;
            timeout_q     <= timeout_d;
            jump_q        <= jump_d;
            best_q        <= best_d;
            best_valid_q  <= best_valid_d;
        end
    end

    assign react_ms    = react_q;
    assign react_valid = react_valid_q;
    assign timeout     = timeout_q;
    assign jump_start  = jump_q;
    assign best_ms     = best_q;
    assign best_valid  = best_valid_q;
    assign busy        = (state_q == ARMED) || (state_q == TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - directed self-checking bench for reaction_timer
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_ms = 1'b0;
    logic        arm = 1'b0;
    logic        lights_out = 1'b0;
    logic        btn_n = 1'b1;
    logic        clear_best = 1'b0;
    logic [13:0] react_ms;
    logic        react_valid;
    logic        timeout;
    logic        jump_start;
    logic [13:0] best_ms;
    logic        best_valid;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    int vcount = 0;

    reaction_timer dut (
        .clk         (clk),
        .rst         (rst),
        .tick_ms     (tick_ms),
        .arm         (arm),
        .lights_out  (lights_out),
        .btn_n       (btn_n),
        .clear_best  (clear_best),
        .react_ms    (react_ms),
        .react_valid (react_valid),
        .timeout     (timeout),
        .jump_start  (jump_start),
        .best_ms     (best_ms),
        .best_valid  (best_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (react_valid === 1'b1) vcount++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) tick_ms = 1'b1;
        @(negedge clk) tick_ms = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_lo();
        @(negedge clk) lights_out = 1'b1;
        @(negedge clk) lights_out = 1'b0;
    endtask

    // press lands in the cycle after the 5th debounce tick; optionally coincide lights_out/tick with it
    task automatic press_btn(input bit with_lo, input bit with_tick);
        @(negedge clk) btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) do_tick();
        @(negedge clk) tick_ms = 1'b1;
        @(negedge clk) begin
            tick_ms    = with_tick;
            lights_out = with_lo;
        end
        @(negedge clk) begin
            tick_ms    = 1'b0;
            lights_out = 1'b0;
        end
    endtask

    task automatic release_btn();
        @(negedge clk) btn_n = 1'b1;
        repeat (3) @(negedge clk);
        repeat (6) do_tick();
    endtask

    task automatic run_result(input int r);
        pulse_arm();
        pulse_lo();
        repeat (r - 5) do_tick();
        press_btn(1'b0, 1'b0);
        release_btn();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_react", 32'(react_ms), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_best_valid", 32'(best_valid), 32'd0);
        rst = 1'b0;

        press_btn(1'b0, 1'b0);
        release_btn();
        chk("idle_press_no_valid", 32'(vcount), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        pulse_arm();
        chk("armed_busy", 32'(busy), 32'd1);
        pulse_lo();
        repeat (240) do_tick();
        press_btn(1'b0, 1'b0);
        chk("normal_react", 32'(react_ms), 32'd245);
        chk("normal_timeout", 32'(timeout), 32'd0);
        chk("normal_best", 32'(best_ms), 32'd245);
        chk("normal_best_valid", 32'(best_valid), 32'd1);
        release_btn();
        chk("normal_valid_once", 32'(vcount), 32'd1);

        pulse_arm();
        press_btn(1'b0, 1'b0);
        chk("jump_flag", 32'(jump_start), 32'd1);
        chk("jump_busy", 32'(busy), 32'd0);
        pulse_lo();
        chk("jump_lo_ignored", 32'(busy), 32'd0);
        release_btn();
        chk("jump_no_valid", 32'(vcount), 32'd1);
        pulse_arm();
        chk("jump_cleared", 32'(jump_start), 32'd0);
        chk("rearm_keeps_react", 32'(react_ms), 32'd245);

        repeat (3) begin
            @(negedge clk) btn_n = 1'b0;
            repeat (3) @(negedge clk);
            do_tick();
            @(negedge clk) btn_n = 1'b1;
            repeat (3) @(negedge clk);
            do_tick();
        end
        @(negedge clk) btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) do_tick();
        @(negedge clk) btn_n = 1'b1;
        repeat (3) @(negedge clk);
        do_tick();
        @(negedge clk) btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) do_tick();
        release_btn();
        chk("glitch_no_jump", 32'(jump_start), 32'd0);
        chk("glitch_still_armed", 32'(busy), 32'd1);

        press_btn(1'b1, 1'b0);
        chk("simul_react", 32'(react_ms), 32'd0);
        chk("simul_jump", 32'(jump_start), 32'd0);
        chk("simul_best", 32'(best_ms), 32'd0);
        release_btn();
        chk("simul_valid", 32'(vcount), 32'd2);

        pulse_arm();
        pulse_lo();
        repeat (9998) do_tick();
        chk("timeout_not_yet", 32'(busy), 32'd1);
        do_tick();
        chk("timeout_react", 32'(react_ms), 32'd9999);
        chk("timeout_flag", 32'(timeout), 32'd1);
        chk("timeout_best_kept", 32'(best_ms), 32'd0);
        do_tick();
        chk("timeout_valid", 32'(vcount), 32'd3);
        pulse_arm();
        chk("rearm_clears_timeout", 32'(timeout), 32'd0);

        @(negedge clk) clear_best = 1'b1;
        @(negedge clk) clear_best = 1'b0;
        chk("clear_best_valid", 32'(best_valid), 32'd0);

        run_result(300);
        chk("best_300", 32'(best_ms), 32'd300);
        run_result(200);
        chk("best_200", 32'(best_ms), 32'd200);
        run_result(200);
        chk("best_200_eq", 32'(best_ms), 32'd200);
        run_result(250);
        chk("best_250_kept", 32'(best_ms), 32'd200);
        chk("react_250", 32'(react_ms), 32'd250);

        @(negedge clk) clear_best = 1'b1;
        run_result(100);
        @(negedge clk) clear_best = 1'b0;
        chk("clear_wins_valid", 32'(best_valid), 32'd0);
        chk("clear_wins_react", 32'(react_ms), 32'd100);
        run_result(400);
        chk("best_400", 32'(best_ms), 32'd400);

        pulse_arm();
        pulse_lo();
        repeat (52) do_tick();
        press_btn(1'b0, 1'b1);
        chk("coincide_react", 32'(react_ms), 32'd57);
        release_btn();
        chk("valid_total", 32'(vcount), 32'd10);

        pulse_arm();
        pulse_lo();
        repeat (10) do_tick();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midrst_react", 32'(react_ms), 32'd0);
        chk("midrst_best", 32'(best_ms), 32'd0);
        chk("midrst_best_valid", 32'(best_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_flags", 32'({react_valid, timeout, jump_start}), 32'd0);
        @(negedge clk) rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Responder side of the start-light sequence. The light FSM and delay initiate "lights out"; this block measures how long the driver takes to answer with a button press.
- It reports the reaction time in milliseconds, flags jump starts, and keeps the session best time.
- It sits beside the light FSM in the top level. It consumes the 1 kHz tick, the sequence-start strobe and the lights-out strobe.
- Its outputs feed bin2bcd_16 and the 7-segment displays.

Parameters:
- DEBOUNCE_MS, 5, number of consecutive stable tick_ms samples needed to accept a new button level.
- MAX_MS, 9999, saturation and timeout value of the reaction counter (fits the 4-digit display).
- CNT_W, 14, width of the ms counters; must satisfy 2^CNT_W > MAX_MS.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- tick_ms, input, 1, one-clk-wide strobe at 1 kHz.
- arm, input, 1, one-cycle strobe when the light sequence starts (start_delay).
- lights_out, input, 1, one-cycle strobe when the random delay expires (time_out).
- btn_n, input, 1, raw active-low push button (asynchronous to clk).
- clear_best, input, 1, synchronous level; clears the best-time record.
- react_ms, output, CNT_W, last measured reaction time; held until the next completion.
- react_valid, output, 1, one-cycle pulse when react_ms is updated.
- timeout, output, 1, high while the last result is a timeout (react_ms = MAX_MS).
- jump_start, output, 1, high from a jump-start detection until the next arm.
- best_ms, output, CNT_W, fastest non-timeout reaction since reset or clear_best.
- best_valid, output, 1, best_ms holds a real value.
- busy, output, 1, high in ARMED or TIMING.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, debounced button level = released.
- Button path:
  - 2-flop synchronizer on btn_n.
  - The debouncer accepts a new level only after DEBOUNCE_MS consecutive tick_ms samples at that level. A disagreeing sample resets the stability count.
  - press = one-clk pulse on the debounced released->pressed transition.
  - Latency from a clean edge to press: 2 clk plus at most DEBOUNCE_MS+1 ticks.
- States:
  - IDLE -> ARMED on arm.
  - ARMED -> JUMP on press without lights_out in the same cycle. Sets jump_start; no react_valid.
  - ARMED -> TIMING on lights_out. Counter cleared to 0.
  - ARMED with press and lights_out in the same cycle -> DONE, react_ms = 0, react_valid pulse (legal, not a jump).
  - TIMING: counter increments by 1 on each tick_ms. On press -> DONE, react_ms = counter value before any same-cycle increment, react_valid pulse.
  - TIMING, no press: when the counter reaches MAX_MS -> DONE, react_ms = MAX_MS, timeout = 1, react_valid pulse. The counter never exceeds MAX_MS.
  - DONE and JUMP -> ARMED on arm. Entering ARMED clears jump_start and timeout; react_ms is kept.
  - arm in ARMED or TIMING: ignored. lights_out outside ARMED: ignored.
- Best time:
  - Updated in the react_valid cycle when timeout = 0 and (best_valid = 0 or react_ms < best_ms).
  - Equal times do not update.
  - clear_best zeroes best_ms and best_valid.
  - clear_best in the same cycle as an update: the clear wins.
- Reset mid-operation: immediate return to the reset values above, including debouncer state and best record.
- busy = (state == ARMED) || (state == TIMING).

Decomposition:
- Package f1_pkg:
  - typedef enum {IDLE, ARMED, TIMING, DONE, JUMP} react_state_t.
  - localparam for the default MAX_MS.
  - typedef ms_t = logic [13:0].
- Sub-module btn_debounce: synchronizer, debounce counter and press-edge output. Parameter DEBOUNCE_MS; ports clk, rst, tick, btn_n, level, press. Reusable for KEY[1] on the light FSM trigger.

Test Plan:
- Reset and idle: assert rst mid-TIMING -> all outputs 0, best_valid 0; press while IDLE -> no react_valid.
- Normal reaction: arm, lights_out, press held clean 240 ticks later -> react_valid once, react_ms = 240 + debounce latency (5 or 6), timeout 0, best_ms updated, best_valid 1.
- Jump start: arm, press before lights_out -> jump_start 1, no react_valid; later lights_out ignored; next arm clears jump_start.
- Timeout: arm, lights_out, no press for 10000 ticks -> react_ms = 9999, timeout 1, best_ms unchanged.
- Best tracking: successive results 300, 200, 200, 250 -> best_ms 300, 200, 200, 200; clear_best -> best_valid 0; next result 400 -> best_ms 400.
- Debounce and simultaneity:
  - Bounce btn_n with 1-tick glitches -> no press.
  - press and lights_out in the same cycle in ARMED -> react_ms 0, jump_start 0.
  - press coinciding with tick_ms in TIMING at count 57 -> react_ms 57.
